// File: rtl/legv8_alu_pkg.sv
// Shared definitions for the LEGv8 execute unit: opcodes, FSM states,
// flag bit positions and the default datapath width.
package legv8_alu_pkg;

    localparam int WIDTH = 64;

    // ALU operation encodings (alu_op)
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_ORR   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MUL   = 4'b1000;

    // Bit positions inside the 4-bit flags word {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Pack individual condition bits into the architectural flags layout.
    function automatic logic [3:0] make_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/legv8_exec_unit_seq_multiplier.sv
// Iterative shift-add multiplier returning the low WIDTH bits of an
// unsigned product. One partial product is accumulated per cycle; done and
// product are valid combinationally during the final step so the parent can
// register the answer on the same edge that retires the last step.
module seq_multiplier
    import legv8_alu_pkg::*;
#(
    parameter int WIDTH     = legv8_alu_pkg::WIDTH,
    parameter int MUL_STEPS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand_in,
    input  logic [WIDTH-1:0] mplier_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             busy_q;
    logic [WIDTH-1:0] acc_next;

    // Accumulator value after the current step; on the last step this is the answer.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = busy_q && (count == LAST_STEP);
    assign product  = acc_next;
    assign busy     = busy_q;

    // Load operands on start, then shift multiplicand left / multiplier right each step.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, exactly like real flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            busy_q <= 1'b0;
        end else if (start && !busy_q) begin
            mcand  <= mcand_in;
            mplier <= mplier_in;
            acc    <= '0;
            count  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (done) begin
                count  <= '0;
                busy_q <= 1'b0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/legv8_exec_unit.sv
// LEGv8 execute-stage unit: single-cycle logical/add/sub ALU plus an
// iterative multiplier, with registered result and NZCV flags. The issue
// side is stalled (in_ready low) while a multiply is in flight.
module legv8_exec_unit
    import legv8_alu_pkg::*;
#(
    parameter int WIDTH     = legv8_alu_pkg::WIDTH,
    parameter int MUL_STEPS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);

    state_t           state;
    logic             accept;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [3:0]       mul_flags;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [3:0]       alu_flags;

    assign in_ready  = (state == ST_IDLE);
    assign busy      = mul_busy;
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (alu_op == OP_MUL);

    seq_multiplier #(
        .WIDTH     (WIDTH),
        .MUL_STEPS (MUL_STEPS)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start     (mul_start),
        .mcand_in  (a),
        .mplier_in (b),
        .busy      (mul_busy),
        .done      (mul_done),
        .product   (mul_product)
    );

    // Single-cycle ALU: result plus carry/overflow for the add/sub family.
    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_op)
            OP_AND:   alu_res = a & b;
            OP_ORR:   alu_res = a | b;
            OP_NOR:   alu_res = ~(a | b);
            OP_PASSB: alu_res = b;
            OP_ADD: begin
                {alu_c, alu_res} = {1'b0, a} + {1'b0, b};
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Carry out of a + ~b + 1 is the inverted borrow.
                {alu_c, alu_res} = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            default:  alu_res = '0;
        endcase
    end

    assign alu_flags = make_flags(alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v);
    assign mul_flags = make_flags(mul_product[WIDTH-1], (mul_product == '0), 1'b0, 1'b0);

    // Control FSM and output registers: single-cycle ops retire on accept,
    // multiplies retire on the multiplier's final step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (alu_op == OP_MUL) begin
                            state <= ST_MUL;
                        end else begin
                            result    <= alu_res;
                            flags     <= alu_flags;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        result    <= mul_product;
                        flags     <= mul_flags;
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_legv8_exec_unit.sv
// Self-checking bench for legv8_exec_unit: directed cases plus randomized
// traffic. The driver pushes expected responses (value, flags, completion
// cycle) into a scoreboard; an independent monitor pops and compares.
module tb_legv8_exec_unit;
    import legv8_alu_pkg::*;

    localparam int W       = 64;
    localparam int MUL_LAT = 65;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic         busy;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flg;
        int           due;
        logic [3:0]   op;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    legv8_exec_unit #(.WIDTH(W), .MUL_STEPS(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .flags     (flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: architectural meaning of each opcode in plain arithmetic.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] x,
                                  input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic [3:0] f);
        logic              c;
        logic              v;
        logic signed [W+1:0] sx;
        logic signed [W+1:0] sy;
        logic signed [W+1:0] s_true;
        logic signed [W+1:0] s_wrap;
        c  = 1'b0;
        v  = 1'b0;
        sx = $signed(x);
        sy = $signed(y);
        case (op)
            OP_AND:   r = x & y;
            OP_ORR:   r = x | y;
            OP_NOR:   r = ~(x | y);
            OP_PASSB: r = y;
            OP_MUL:   r = x * y;
            OP_ADD: begin
                r      = x + y;
                c      = (r < x);
                s_true = sx + sy;
                s_wrap = $signed(r);
                v      = (s_true != s_wrap);
            end
            OP_SUB: begin
                r      = x - y;
                c      = (x >= y);
                s_true = sx - sy;
                s_wrap = $signed(r);
                v      = (s_true != s_wrap);
            end
            default:  r = '0;
        endcase
        f = {r[W-1], (r == '0), c, v};
    endfunction

    // Monitor: compare every completion against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got result %h with no pending op (cycle %0d)", result, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("result op=%b", e.op), result, e.res);
                    check($sformatf("flags op=%b", e.op), W'(flags), W'(e.flg));
                    check($sformatf("latency op=%b", e.op), W'(cyc), W'(e.due));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_out_valid op=%b: got none expected at cycle %0d (now %0d)", e.op, e.due, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        alu_op   = 4'($urandom);
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
    endtask

    // Offer one op (holding the previous offer while stalled) and advance one cycle.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        int   waited;
        exp_t e;
        waited = 0;
        while (!in_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready got 0 expected 1 within 200 cycles (cycle %0d)", cyc);
            return;
        end
        in_valid = 1'b1;
        alu_op   = op;
        a        = x;
        b        = y;
        model(op, x, y, e.res, e.flg);
        e.op  = op;
        e.due = cyc + ((op == OP_MUL) ? MUL_LAT : 1);
        sb.push_back(e);
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  W'(in_ready),  W'(1));
        check({tag, "_busy"},      W'(busy),      W'(0));
        check({tag, "_out_valid"}, W'(out_valid), W'(0));
        check({tag, "_result"},    result,        '0);
        check({tag, "_flags"},     W'(flags),     W'(0));
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corners[5];
        corners[0] = '0;
        corners[1] = W'(1);
        corners[2] = '1;
        corners[3] = {1'b0, {(W-1){1'b1}}};
        corners[4] = {1'b1, {(W-1){1'b0}}};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return {$urandom, $urandom};
    endfunction

    initial begin
        int low_cycles;
        int drain;
        logic [3:0] ops[8];
        ops[0] = OP_AND; ops[1] = OP_ORR; ops[2] = OP_ADD; ops[3] = OP_SUB;
        ops[4] = OP_PASSB; ops[5] = OP_NOR; ops[6] = OP_MUL; ops[7] = 4'b0000;

        // Reset with in_valid high: nothing may be accepted.
        reset    = 1'b1;
        in_valid = 1'b1;
        alu_op   = OP_ADD;
        a        = W'(9);
        b        = W'(9);
        repeat (3) tick();
        reset = 1'b0;
        idle();
        check_reset_state("por");

        // Directed single-cycle cases.
        issue(OP_ADD, W'(5), W'(7));
        idle(); tick();
        issue(OP_SUB, W'(5), W'(5));
        idle(); tick();
        issue(OP_SUB, W'(0), W'(1));
        idle(); tick();
        issue(OP_ADD, {1'b0, {(W-1){1'b1}}}, W'(1));
        idle(); tick();

        // Multiply: stall length with ignored in_valid pulses while busy.
        issue(OP_MUL, W'(64'h1_0000_0000), W'(3));
        low_cycles = 0;
        for (int i = 0; i < 70; i++) begin
            if (!in_ready) low_cycles++;
            check("busy_vs_ready", W'(busy), W'(!in_ready));
            in_valid = (i % 2 == 0) && !in_ready;
            alu_op   = OP_ADD;
            a        = {$urandom, $urandom};
            b        = {$urandom, $urandom};
            tick();
        end
        idle();
        check("mul_stall_cycles", W'(low_cycles), W'(64));

        // Back-to-back single-cycle ops.
        issue(OP_ORR, W'(8'hF0), W'(8'h0F));
        issue(OP_NOR, '0, '0);
        idle(); tick(); tick();

        // Reset 30 cycles into a multiply: aborted, never completes.
        issue(OP_MUL, {$urandom, $urandom}, {$urandom, $urandom});
        idle();
        repeat (29) tick();
        reset = 1'b1;
        sb.delete();
        tick();
        reset = 1'b0;
        check_reset_state("mid_mul_reset");
        repeat (100) tick();
        issue(OP_ADD, W'(1), W'(1));
        idle(); tick(); tick();

        // Randomized traffic with random gaps and back-to-back issues.
        for (int n = 0; n < 120; n++) begin
            logic [3:0] op;
            int sel;
            sel = $urandom_range(0, 15);
            if (sel < 8)       op = ops[sel];
            else if (sel < 14) op = ops[$urandom_range(0, 5)];
            else               op = 4'($urandom);
            if (op == OP_MUL && $urandom_range(0, 1) == 0) op = OP_ADD;
            issue(op, pick_operand(), pick_operand());
            if ($urandom_range(0, 2) == 0) begin
                idle();
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        idle();

        drain = 0;
        while (sb.size() > 0 && drain < 200) begin
            tick();
            drain++;
        end
        tick();
        check("scoreboard_drained", W'(sb.size()), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
